// File: rtl/sensor_packet_builder.sv
// Builds a fixed 32-byte IMU packet (header, seq, 12 sensor words, timestamp,
// overrun count, XOR checksum) and holds it for the SPI slave until acknowledged.
module sensor_packet_builder #(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter int         TICK_DIV = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         sample_valid,
  // Each 48-bit sensor bus is {x, y, z}, x in bits [47:32].
  input  logic [47:0]  accel_a,
  input  logic [47:0]  gyro_a,
  input  logic [47:0]  accel_b,
  input  logic [47:0]  gyro_b,
  // Packet byte k sits in data_bytes[8*k +: 8].
  output logic [255:0] data_bytes,
  output logic         data_ready,
  input  logic         data_ack,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    READY = 2'd2
  } state_e;

  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

  state_e         state_q, state_d;
  logic [255:0]   bytes_q, bytes_d;
  logic [7:0]     seq_q, seq_d;
  logic [7:0]     ovr_q, ovr_d;
  logic [7:0]     acc_q, acc_d;
  logic [4:0]     idx_q, idx_d;
  logic [31:0]    ts_q;
  logic [15:0]    pre_q;
  logic [191:0]   words;
  logic [255:0]   cap_bytes;
  logic [7:0]     cur_byte;
  logic           take;

  assign take     = enable & sample_valid;
  assign words    = {accel_a, gyro_a, accel_b, gyro_b};
  assign cur_byte = bytes_q[{idx_q, 3'b000} +: 8];

  // Free-running timestamp, independent of the packet FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      ts_q  <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      ts_q  <= ts_q + 32'd1;
    end else begin
      pre_q <= pre_q + 16'd1;
    end
  end

  always_comb begin
    cap_bytes        = '0;
    cap_bytes[7:0]   = HEADER;
    cap_bytes[15:8]  = seq_q;
    for (int i = 0; i < 12; i++) begin
      cap_bytes[8*(2+2*i) +: 8] = words[191-16*i -: 8];
      cap_bytes[8*(3+2*i) +: 8] = words[183-16*i -: 8];
    end
    cap_bytes[215:208] = ts_q[31:24];
    cap_bytes[223:216] = ts_q[23:16];
    cap_bytes[231:224] = ts_q[15:8];
    cap_bytes[239:232] = ts_q[7:0];
    cap_bytes[247:240] = ovr_q;
  end

  // Handshake: data_ready is high exactly while in READY and data_bytes is frozen;
  // a data_ack seen in READY releases the packet on that edge, ack is ignored elsewhere.
  always_comb begin
    state_d = state_q;
    bytes_d = bytes_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          bytes_d = cap_bytes;
          seq_d   = seq_q + 8'd1;
          ovr_d   = '0;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SUM;
        end
      end
      SUM: begin
        acc_d = acc_q ^ cur_byte;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd30) begin
          bytes_d[255:248] = acc_q ^ cur_byte;
          state_d          = READY;
        end
        if (take && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end
      READY: begin
        if (data_ack) state_d = IDLE;
        if (take && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bytes_q <= '0;
      seq_q   <= '0;
      ovr_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bytes_q <= bytes_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  assign data_bytes = bytes_q;
  assign data_ready = (state_q == READY);
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sensor_packet_builder.sv
// Directed bench for sensor_packet_builder: expected packets are queued at the
// capture strobe and compared when data_ready rises.
module tb_sensor_packet_builder;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         sample_valid;
  logic [47:0]  accel_a, gyro_a, accel_b, gyro_b;
  logic [255:0] data_bytes;
  logic         data_ready;
  logic         data_ack;
  logic         busy;
  logic [1:0]   dbg_state;

  sensor_packet_builder #(.HEADER(8'hA5), .TICK_DIV(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .accel_a      (accel_a),
    .gyro_a       (gyro_a),
    .accel_b      (accel_b),
    .gyro_b       (gyro_b),
    .data_bytes   (data_bytes),
    .data_ready   (data_ready),
    .data_ack     (data_ack),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Timestamp model for TICK_DIV=1: one tick per clock edge out of reset.
  logic [31:0] m_ts;
  always @(posedge clk or posedge reset) begin
    if (reset) m_ts <= '0;
    else       m_ts <= m_ts + 32'd1;
  end

  logic [255:0] exp_q[$];
  logic [255:0] last_pkt;
  logic [15:0]  cur_w[12];
  logic [7:0]   nseq;
  logic [7:0]   novr;
  logic         in_flight;
  int           vectors;
  int           miscompares;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_pkt(input logic [7:0] sq, input logic [7:0] ov,
                                             input logic [31:0] ts, input logic [15:0] w[12]);
    logic [7:0]   b[32];
    logic [7:0]   x;
    logic [255:0] p;
    b[0] = 8'hA5;
    b[1] = sq;
    for (int i = 0; i < 12; i++) begin
      b[2+2*i] = w[i][15:8];
      b[3+2*i] = w[i][7:0];
    end
    b[26] = ts[31:24];
    b[27] = ts[23:16];
    b[28] = ts[15:8];
    b[29] = ts[7:0];
    b[30] = ov;
    x = '0;
    for (int i = 0; i < 31; i++) x = x ^ b[i];
    b[31] = x;
    for (int i = 0; i < 32; i++) p[8*i +: 8] = b[i];
    return p;
  endfunction

  task automatic clear_words();
    for (int i = 0; i < 12; i++) cur_w[i] = '0;
  endtask

  task automatic drive_words();
    accel_a = {cur_w[0], cur_w[1], cur_w[2]};
    gyro_a  = {cur_w[3], cur_w[4], cur_w[5]};
    accel_b = {cur_w[6], cur_w[7], cur_w[8]};
    gyro_b  = {cur_w[9], cur_w[10], cur_w[11]};
  endtask

  // Called at a negedge; the strobe is seen on the next posedge; returns at the following negedge.
  task automatic strobe(input logic en);
    drive_words();
    enable       = en;
    sample_valid = 1'b1;
    if (en && !in_flight) begin
      exp_q.push_back(model_pkt(nseq, novr, m_ts, cur_w));
      nseq      = nseq + 8'd1;
      novr      = '0;
      in_flight = 1'b1;
    end else if (en && novr != 8'hFF) begin
      novr = novr + 8'd1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    enable       = 1'b1;
  endtask

  // Called right after a capturing strobe; expects data_ready 31 edges after capture.
  task automatic expect_packet(input string tag);
    int   n;
    logic busy_ok;
    n       = 0;
    busy_ok = 1'b1;
    while (!data_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, n, 31);
    chk({tag, "_busy"}, busy_ok, 1'b1);
    chk({tag, "_queue"}, exp_q.size() != 0, 1'b1);
    last_pkt = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_bytes"}, data_bytes, last_pkt);
    @(negedge clk);
  endtask

  task automatic ack();
    data_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_ready_low", data_ready, 1'b0);
    @(negedge clk);
    data_ack  = 1'b0;
    in_flight = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    nseq      = '0;
    novr      = '0;
    in_flight = 1'b0;
  endtask

  initial begin
    logic [7:0] prev_seq;
    logic       saw_wrap;
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b0;
    data_ack     = 1'b0;
    clear_words();
    drive_words();
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bytes", data_bytes, '0);
    chk("rst_state", dbg_state, 2'd0);
    reset = 1'b0;

    // All-zero sensors, captured on the 10th edge after reset release.
    repeat (9) @(posedge clk);
    @(negedge clk);
    strobe(1'b1);
    expect_packet("zero");
    chk("zero_ts_byte29", data_bytes[239:232], 8'd9);
    ack();

    // Word ordering and byte endianness.
    cur_w[0]  = 16'h1234;
    cur_w[11] = 16'hABCD;
    strobe(1'b1);
    expect_packet("order");
    chk("order_b2", data_bytes[23:16], 8'h12);
    chk("order_b3", data_bytes[31:24], 8'h34);
    chk("order_b24", data_bytes[199:192], 8'hAB);
    chk("order_b25", data_bytes[207:200], 8'hCD);
    ack();
    clear_words();

    // Long hold in READY with three dropped samples.
    strobe(1'b1);
    expect_packet("hold");
    prev_seq = data_bytes[15:8];
    for (int i = 0; i < 100; i++) begin
      if (i == 10 || i == 40 || i == 70) strobe(1'b1);
      else @(negedge clk);
    end
    chk("hold_bytes", data_bytes, last_pkt);
    chk("hold_ready", data_ready, 1'b1);
    ack();
    strobe(1'b1);
    expect_packet("after_hold");
    chk("after_hold_ovr", data_bytes[247:240], 8'h03);
    chk("after_hold_seq", data_bytes[15:8], prev_seq + 8'd1);
    ack();

    // Overrun saturation.
    strobe(1'b1);
    expect_packet("sat_pre");
    repeat (300) strobe(1'b1);
    ack();
    strobe(1'b1);
    expect_packet("sat");
    chk("sat_ovr", data_bytes[247:240], 8'hFF);
    ack();
    strobe(1'b1);
    expect_packet("sat_clr");
    chk("sat_clr_ovr", data_bytes[247:240], 8'h00);
    ack();

    // 257 random packets: sequence number must wrap.
    saw_wrap = 1'b0;
    prev_seq = last_pkt[15:8];
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < 12; i++) cur_w[i] = 16'($urandom_range(0, 65535));
      strobe(1'b1);
      expect_packet("rand");
      if (prev_seq == 8'hFF && data_bytes[15:8] == 8'h00) saw_wrap = 1'b1;
      prev_seq = data_bytes[15:8];
      ack();
    end
    chk("seq_wrap", saw_wrap, 1'b1);
    clear_words();

    // Ack and sample in the same READY cycle; then a disabled strobe.
    strobe(1'b1);
    expect_packet("same");
    data_ack     = 1'b1;
    sample_valid = 1'b1;
    novr         = novr + 8'd1;
    @(posedge clk);
    #1;
    chk("same_ready", data_ready, 1'b0);
    chk("same_state", dbg_state, 2'd0);
    @(negedge clk);
    data_ack     = 1'b0;
    sample_valid = 1'b0;
    in_flight    = 1'b0;
    repeat (3) @(negedge clk);
    chk("same_no_capture", busy, 1'b0);
    strobe(1'b0);
    repeat (3) @(negedge clk);
    chk("disabled_no_capture", busy, 1'b0);
    strobe(1'b1);
    expect_packet("same_next");
    chk("same_next_ovr", data_bytes[247:240], 8'h01);
    ack();

    // Reset in the middle of SUM.
    strobe(1'b1);
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_sum_ready", data_ready, 1'b0);
    chk("rst_sum_busy", busy, 1'b0);
    chk("rst_sum_bytes", data_bytes, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    strobe(1'b1);
    expect_packet("post_rst_sum");
    chk("post_rst_sum_seq", data_bytes[15:8], 8'h00);

    // Reset while READY.
    reset = 1'b1;
    #1;
    chk("rst_ready_ready", data_ready, 1'b0);
    chk("rst_ready_bytes", data_bytes, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    strobe(1'b1);
    expect_packet("post_rst_ready");
    chk("post_rst_ready_seq", data_bytes[15:8], 8'h00);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
